// File: rtl/uart_frame_rx_ctrl.sv
// Receive-side frame controller for the UART image link: finds the header, packs payload bytes
// into 16-bit FIFO words (low byte first) and validates the trailer.
module uart_frame_rx_ctrl #(
    parameter int unsigned IMAGE_SIZE = 8,
    parameter logic [7:0]  SEND_MODE  = 8'h01,
    parameter logic [19:0] TIMEOUT    = 20'd100000
) (
    input  logic        SYS_CLK,
    input  logic        RST_N,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_clk,
    output logic        wr_req,
    output logic [15:0] wr_data,
    input  logic        wr_full,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [2:0] StHunt = 3'd0;
    localparam logic [2:0] StHdr1 = 3'd1;
    localparam logic [2:0] StLo   = 3'd2;
    localparam logic [2:0] StHi   = 3'd3;
    localparam logic [2:0] StTrl0 = 3'd4;
    localparam logic [2:0] StTrl1 = 3'd5;

    localparam logic [7:0]  ModeInv   = ~SEND_MODE;
    localparam logic [16:0] LastWord  = 17'(IMAGE_SIZE);
    localparam logic [20:0] TmoLimit  = {1'b0, TIMEOUT};

    logic [2:0]  state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        ovf_q, ovf_d;
    logic [19:0] tmo_q, tmo_d;
    logic [7:0]  low_q, low_d;
    logic        wr_req_q, wr_req_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        tmo_run;
    logic        tmo_hit;
    logic [16:0] word_cnt_inc;

    // The inter-byte timer only guards the body of a frame, not the header hunt.
    assign tmo_run      = (state_q != StHunt) && (state_q != StHdr1);
    assign tmo_hit      = tmo_run && !rx_valid && (({1'b0, tmo_q} + 21'd1) == TmoLimit);
    assign word_cnt_inc = {1'b0, word_cnt_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;
        low_d      = low_q;
        wr_req_d   = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (tmo_hit) begin
            state_d = StHunt;
            tmo_d   = '0;
            err_d   = 1'b1;
        end else if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                StHunt: begin
                    if (rx_data == SEND_MODE) begin
                        state_d = StHdr1;
                    end
                end
                StHdr1: begin
                    if (rx_data == ModeInv) begin
                        state_d    = StLo;
                        word_cnt_d = '0;
                        ovf_d      = 1'b0;
                    end else if (rx_data != SEND_MODE) begin
                        state_d = StHunt;
                    end
                end
                StLo: begin
                    low_d   = rx_data;
                    state_d = StHi;
                end
                StHi: begin
                    // A word that meets a full FIFO is dropped but still counted.
                    if (wr_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_req_d  = 1'b1;
                        wr_data_d = {rx_data, low_q};
                    end
                    word_cnt_d = word_cnt_inc[15:0];
                    state_d    = (word_cnt_inc == LastWord) ? StTrl0 : StLo;
                end
                StTrl0: begin
                    if (rx_data == ModeInv) begin
                        state_d = StTrl1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StHunt;
                    end
                end
                StTrl1: begin
                    if ((rx_data == SEND_MODE) && !ovf_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StHunt;
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end else if (tmo_run) begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            state_q    <= StHunt;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= '0;
            low_q      <= '0;
            wr_req_q   <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            low_q      <= low_d;
            wr_req_q   <= wr_req_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // FIFO samples mid-cycle, well after the registered request settles.
    assign wr_clk     = ~SYS_CLK;
    assign wr_req     = wr_req_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != StHunt);

endmodule
